tog_rx: RTL and testbench

TOG_RX -- requirements
Module: tog_rx

---
 rtl/tog_rx.sv | 72 +++++++
 tb/tb_tog_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tog_rx.sv
// Toggle-event receiver: synchronises a toggle line from a T-flop sender and
// keeps a count of pending events. Each consumed event inverts ack_tog.
module tog_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tog_in,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              ack_tog,
  output logic [PEND_W-1:0] pend_cnt,
  output logic [15:0]       evt_total,
  output logic              ovf,
  input  logic              clr_ovf
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;
  logic                   prev_q;
  logic                   detect;
  logic                   consume;
  logic                   full;
  logic                   drop;

  // NOTE: the synchroniser and edge register carry no reset on purpose; they
  // keep tracking tog_in through reset so a level held across it is no event.
  always_ff @(posedge clk) begin
    sync_ff <= {sync_ff[SYNC_STAGES-2:0], tog_in};
    prev_q  <= sync_q;
  end

  assign sync_q    = sync_ff[SYNC_STAGES-1];
  assign detect    = sync_q ^ prev_q;
  assign evt_valid = (pend_cnt != '0);
  assign consume   = evt_valid & evt_ready;
  assign full      = (pend_cnt == PEND_MAX);
  assign drop      = detect & ~consume & full;

  // NOTE: all state below uses non-blocking assignments so every update in
  // this block sees the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt  <= '0;
      evt_total <= '0;
      ovf       <= 1'b0;
      ack_tog   <= 1'b0;
    end else begin
      if (detect)
        evt_total <= evt_total + 16'd1;

      if (consume)
        ack_tog <= ~ack_tog;

      // A coincident detect and consume cancel out, even when full.
      if (detect && !consume && !full)
        pend_cnt <= pend_cnt + PEND_ONE;
      else if (!detect && consume)
        pend_cnt <= pend_cnt - PEND_ONE;

      if (drop)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tog_rx.sv
// Self-checking bench for tog_rx: directed vector table, hand-written corner
// sequences, and a randomized run compared every cycle against a reference model.
module tb_tog_rx;

  localparam int S      = 2;
  localparam int PEND_W = 4;
  localparam int PMAX   = (1 << PEND_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              tog_in;
  logic              evt_valid;
  logic              evt_ready;
  logic              ack_tog;
  logic [PEND_W-1:0] pend_cnt;
  logic [15:0]       evt_total;
  logic              ovf;
  logic              clr_ovf;

  int n_chk = 0;
  int n_err = 0;

  tog_rx #(.SYNC_STAGES(S), .PEND_W(PEND_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .tog_in    (tog_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .ack_tog   (ack_tog),
    .pend_cnt  (pend_cnt),
    .evt_total (evt_total),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an event becomes visible S edges after the edge that
  // first sampled the new tog_in level, unless reset is high at that edge.
  int   m_pend  = 0;
  int   m_total = 0;
  bit   m_ack   = 0;
  bit   m_ovf   = 0;
  logic hist[$];

  initial begin
    bit det, cons, drop;
    forever begin
      @(posedge clk);
      hist.push_back(tog_in);
      if (hist.size() > S + 2) void'(hist.pop_front());
      det = (hist.size() == S + 2) && (hist[1] != hist[0]);
      if (rst) begin
        m_pend = 0; m_total = 0; m_ack = 0; m_ovf = 0;
      end else begin
        cons = (m_pend != 0) && evt_ready;
        drop = det && !cons && (m_pend == PMAX);
        if (det) m_total = (m_total + 1) % 65536;
        if (cons) m_ack = !m_ack;
        if (det && !cons && !drop) m_pend++;
        else if (!det && cons) m_pend--;
        if (drop) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("mdl_pend",  32'(pend_cnt),  32'(m_pend));
      check("mdl_total", 32'(evt_total), 32'(m_total));
      check("mdl_valid", 32'(evt_valid), 32'(m_pend != 0));
      check("mdl_ack",   32'(ack_tog),   32'(m_ack));
      check("mdl_ovf",   32'(ovf),       32'(m_ovf));
    end
  end

  typedef struct {
    logic              tog, ready, clr, rst;
    int                cyc;
    logic [PEND_W-1:0] pend;
    logic [15:0]       total;
    logic              valid, ack, ovf;
  } vec_t;

  vec_t tbl[12];

  task automatic expect_all(input string tag, input int p, input int t,
                            input bit v, input bit a, input bit o);
    check({tag, "_pend"},  32'(pend_cnt),  32'(p));
    check({tag, "_total"}, 32'(evt_total), 32'(t));
    check({tag, "_valid"}, 32'(evt_valid), 32'(v));
    check({tag, "_ack"},   32'(ack_tog),   32'(a));
    check({tag, "_ovf"},   32'(ovf),       32'(o));
  endtask

  task automatic toggle_hold(input int n);
    tog_in = ~tog_in;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int hold;
    rst = 1'b1; tog_in = 1'b1; evt_ready = 1'b0; clr_ovf = 1'b0;

    //            tog ready clr rst cyc pend total valid ack ovf
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5,  4'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  4'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  4'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  4'd1, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  4'd1, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2,  4'd1, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  4'd2, 16'd2, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1,  4'd1, 16'd2, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1,  4'd0, 16'd2, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,  4'd0, 16'd2, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2,  4'd0, 16'd2, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      tog_in = tbl[i].tog; evt_ready = tbl[i].ready;
      clr_ovf = tbl[i].clr; rst = tbl[i].rst;
      repeat (tbl[i].cyc) @(negedge clk);
      expect_all($sformatf("row%0d", i), int'(tbl[i].pend), int'(tbl[i].total),
                 tbl[i].valid, tbl[i].ack, tbl[i].ovf);
    end

    // Fill to capacity and overflow, then clear the sticky flag.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    repeat (17) toggle_hold(4);
    expect_all("fill", PMAX, 17, 1'b1, 1'b0, 1'b1);
    clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
    expect_all("clr", PMAX, 17, 1'b1, 1'b0, 1'b0);

    // Overflow in the same cycle as clr_ovf keeps the flag set.
    tog_in = ~tog_in; repeat (2) @(negedge clk);
    clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
    expect_all("ovf_wins", PMAX, 18, 1'b1, 1'b0, 1'b1);
    clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
    check("clr2_ovf", 32'(ovf), 32'd0);

    // Detect coincident with consume while full: nothing dropped.
    tog_in = ~tog_in; repeat (2) @(negedge clk);
    evt_ready = 1'b1; @(negedge clk); evt_ready = 1'b0;
    expect_all("full_cons", PMAX, 19, 1'b1, 1'b1, 1'b0);

    // Mid-operation reset discards pending events.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    repeat (9) toggle_hold(4);
    expect_all("nine", 9, 9, 1'b1, 1'b0, 1'b0);
    evt_ready = 1'b1; repeat (4) @(negedge clk); evt_ready = 1'b0;
    expect_all("five", 5, 9, 1'b1, 1'b0, 1'b0);
    rst = 1'b1; @(negedge clk);
    expect_all("mid_rst", 0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    toggle_hold(4);
    expect_all("post_rst", 1, 1, 1'b1, 1'b0, 1'b0);

    // Randomized traffic; levels held at least S+1 cycles.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      evt_ready = ($urandom_range(0, 99) < (((c / 500) % 2 == 1) ? 70 : 15));
      clr_ovf   = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      if (hold == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          tog_in = ~tog_in;
          hold   = $urandom_range(S + 1, S + 4);
        end
      end else begin
        hold--;
      end
      @(negedge clk);
    end

    rst = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
